// File: rtl/support_pkg.sv
// support_pkg: constants and helpers shared by the support-CPU SPI receive path.
//   - SPI framing constants (bits per byte, idle pin levels)
//   - status-byte field layout returned on MISO
//   - default FIFO depth
package support_pkg;

    localparam int          SPI_BITS      = 8;
    localparam int          SPI_BCW       = $clog2(SPI_BITS);
    localparam logic        SPI_SS_IDLE   = 1'b1;
    localparam logic        SPI_SCK_IDLE  = 1'b0;
    localparam logic        SPI_MISO_IDLE = 1'b1;

    // Status byte: {overrun, free[6:0]}
    localparam int          STAT_OVR_BIT  = 7;
    localparam int          STAT_FREE_W   = 7;
    localparam int unsigned STAT_FREE_MAX = (1 << STAT_FREE_W) - 1;

    localparam int          DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic ss_n;
        logic sck;
        logic mosi;
    } spi_pins_t;

    localparam spi_pins_t SPI_PINS_IDLE = '{ss_n: SPI_SS_IDLE, sck: SPI_SCK_IDLE, mosi: 1'b0};

    // Free space saturates so large FIFOs still fit the 7-bit field.
    function automatic logic [SPI_BITS-1:0] status_byte(input logic ovr, input int unsigned free_bytes);
        logic [SPI_BITS-1:0] s;
        s = '0;
        s[STAT_OVR_BIT] = ovr;
        s[STAT_FREE_W-1:0] = (free_bytes > STAT_FREE_MAX) ? STAT_FREE_W'(STAT_FREE_MAX)
                                                          : STAT_FREE_W'(free_bytes);
        return s;
    endfunction

endpackage

// File: rtl/support_byte_fifo.sv
// support_byte_fifo: dual-pointer show-ahead byte FIFO.
//   clk_i, n_reset_i     clock, async active-low reset
//   push_i, push_data_i  write one byte (caller guarantees not full, or popping)
//   pop_i                drop the head byte (caller guarantees not empty)
//   full_o, empty_o      combinational from the registered count
//   count_o              bytes held, 0..DEPTH
//   d_avail_o, data_o    registered head view, one edge behind count/pointers
module support_byte_fifo
    import support_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic                clk_i,
    input  logic                n_reset_i,
    input  logic                push_i,
    input  logic [SPI_BITS-1:0] push_data_i,
    input  logic                pop_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [AW:0]         count_o,
    output logic                d_avail_o,
    output logic [SPI_BITS-1:0] data_o
);

    logic [SPI_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                d_avail_q, d_avail_d;
    logic [SPI_BITS-1:0] data_q, data_d;

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(push_i);
        rd_ptr_d  = rd_ptr_q + AW'(pop_i);
        count_d   = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        d_avail_d = (count_q != '0);
        data_d    = d_avail_d ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            d_avail_q <= 1'b0;
            data_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            d_avail_q <= d_avail_d;
            data_q    <= data_d;
        end
    end

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign d_avail_o = d_avail_q;
    assign data_o    = data_q;

endmodule

// File: rtl/support_spi_rx.sv
// support_spi_rx: SPI mode-0 slave receiver feeding the code-upload DMA.
//   clk_i, n_reset_i                 system clock, async active-low reset
//   spi_sck_i, spi_ss_n_i, spi_mosi_i async SPI pins (synchronised here)
//   spi_miso_o                       status byte {overrun, free[6:0]}, 1 while idle
//   rd_i                             one-cycle pop strobe from the DMA
//   d_avail_o, data_o, count_o       show-ahead FIFO head and fill level
//   overrun_o                        sticky dropped-byte flag
// Optional feature macro: SUPPORT_SPI_RX_OVERRUN_EN builds the overrun flag;
// without it overrun_o and status bit 7 are tied to 0.
module support_spi_rx
    import support_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic                clk_i,
    input  logic                n_reset_i,
    input  logic                spi_sck_i,
    input  logic                spi_ss_n_i,
    input  logic                spi_mosi_i,
    output logic                spi_miso_o,
    input  logic                rd_i,
    output logic                d_avail_o,
    output logic [SPI_BITS-1:0] data_o,
    output logic [AW:0]         count_o,
    output logic                overrun_o
);

    localparam int unsigned DEPTH_U = DEPTH;

    spi_pins_t pins_in, sync1_q, sync2_q;
    logic      sck_dly_q, ss_dly_q;
    logic      sck_rise, sck_fall, ss_fall, ss_act;

    logic [SPI_BITS-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, status;
    logic [SPI_BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic                push_req_q, push_req_d;
    logic                tx_skip_q, tx_skip_d;
    logic                ovr;

    logic                fifo_full, fifo_empty, pop, push_ok;
    logic [AW:0]         fifo_count;

    assign pins_in = '{ss_n: spi_ss_n_i, sck: spi_sck_i, mosi: spi_mosi_i};

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            sync1_q   <= SPI_PINS_IDLE;
            sync2_q   <= SPI_PINS_IDLE;
            sck_dly_q <= SPI_SCK_IDLE;
            ss_dly_q  <= SPI_SS_IDLE;
        end else begin
            sync1_q   <= pins_in;
            sync2_q   <= sync1_q;
            sck_dly_q <= sync2_q.sck;
            ss_dly_q  <= sync2_q.ss_n;
        end
    end

    assign sck_rise = sync2_q.sck & ~sck_dly_q;
    assign sck_fall = ~sync2_q.sck & sck_dly_q;
    assign ss_fall  = ~sync2_q.ss_n & ss_dly_q;
    assign ss_act   = ~sync2_q.ss_n;

    assign status = status_byte(ovr, DEPTH_U - 32'(fifo_count));

    // Byte completion happens on the 8th rise, but mode 0 still delivers the
    // 8th fall afterwards; that fall must not shift away the freshly loaded
    // status MSB, so it is consumed via tx_skip instead of shifting.
    always_comb begin
        rx_sh_d    = rx_sh_q;
        bit_cnt_d  = bit_cnt_q;
        push_req_d = 1'b0;
        tx_sh_d    = tx_sh_q;
        tx_skip_d  = tx_skip_q;
        if (!ss_act) begin
            bit_cnt_d = '0;
            tx_sh_d   = {SPI_BITS{SPI_MISO_IDLE}};
            tx_skip_d = 1'b0;
        end else begin
            if (sck_rise) begin
                rx_sh_d   = {rx_sh_q[SPI_BITS-2:0], sync2_q.mosi};
                bit_cnt_d = bit_cnt_q + SPI_BCW'(1);
                if (bit_cnt_q == SPI_BCW'(SPI_BITS - 1)) begin
                    push_req_d = 1'b1;
                    tx_sh_d    = status;
                    tx_skip_d  = 1'b1;
                end
            end else if (sck_fall) begin
                if (tx_skip_q) tx_skip_d = 1'b0;
                else           tx_sh_d   = {tx_sh_q[SPI_BITS-2:0], SPI_MISO_IDLE};
            end
            if (ss_fall) begin
                tx_sh_d   = status;
                tx_skip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            rx_sh_q    <= '0;
            bit_cnt_q  <= '0;
            push_req_q <= 1'b0;
            tx_sh_q    <= {SPI_BITS{SPI_MISO_IDLE}};
            tx_skip_q  <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            bit_cnt_q  <= bit_cnt_d;
            push_req_q <= push_req_d;
            tx_sh_q    <= tx_sh_d;
            tx_skip_q  <= tx_skip_d;
        end
    end

    // fifo_empty guards the cycle after the last pop, when d_avail_o still lags high.
    assign pop     = rd_i & d_avail_o & ~fifo_empty;
    assign push_ok = push_req_q & (~fifo_full | pop);

`ifdef SUPPORT_SPI_RX_OVERRUN_EN
    logic ovr_q;
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i)                 ovr_q <= 1'b0;
        else if (push_req_q & ~push_ok) ovr_q <= 1'b1;
    end
    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    support_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk_i       (clk_i),
        .n_reset_i   (n_reset_i),
        .push_i      (push_ok),
        .push_data_i (rx_sh_q),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .d_avail_o   (d_avail_o),
        .data_o      (data_o)
    );

    assign count_o    = fifo_count;
    assign overrun_o  = ovr;
    assign spi_miso_o = tx_sh_q[SPI_BITS-1];

endmodule

// File: tb/tb_support_spi_rx.sv
module tb_support_spi_rx;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HALF  = 4;   // SCK half period in clk cycles

`ifdef SUPPORT_SPI_RX_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          n_reset, sck, ss_n, mosi, miso, rd, d_avail, ovr;
    logic [7:0]    data;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    support_spi_rx #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i      (clk),
        .n_reset_i  (n_reset),
        .spi_sck_i  (sck),
        .spi_ss_n_i (ss_n),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .rd_i       (rd),
        .d_avail_o  (d_avail),
        .data_o     (data),
        .count_o    (count),
        .overrun_o  (ovr)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] q[$];      // reference FIFO contents, head at q[0]
    logic       m_ovr;
    logic [7:0] stat_exp;  // status byte the master should see on the next byte
    logic [7:0] mb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        int f;
        f = DEPTH - q.size();
        if (f > 127) f = 127;
        return {m_ovr, 7'(f)};
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else if (OVR_EN)      m_ovr = 1'b1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, " count"}, count, q.size());
        chk({tag, " avail"}, d_avail, q.size() != 0);
        if (q.size() != 0) chk({tag, " data"}, data, q[0]);
        chk({tag, " ovr"}, ovr, m_ovr);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        n_reset = 1'b0; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; rd = 1'b0;
        #1;
        chk({tag, " rst count"}, count, 0);
        chk({tag, " rst avail"}, d_avail, 0);
        chk({tag, " rst data"}, data, 0);
        chk({tag, " rst ovr"}, ovr, 0);
        chk({tag, " rst miso"}, miso, 1);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        ss_n = 1'b0;
        stat_exp = m_status();
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Shifts nbits MSB first; optionally strobes rd_i so the pop lands on the
    // edge that writes the byte (3 edges after the last rise is registered).
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit pop_last,
                             output logic [7:0] mo);
        mo = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (HALF) @(negedge clk);
            mo[7-i] = miso;
            sck = 1'b1;
            if (pop_last && i == nbits - 1) begin
                repeat (3) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_last, input string tag,
                             output logic [7:0] mo);
        send_bits(b, 8, pop_last, mo);
        chk({tag, " miso"}, mo, stat_exp);
        // Next status is captured at this byte's completion, before its push lands.
        stat_exp = m_status();
        if (pop_last && q.size() != 0) void'(q.pop_front());
        m_push(b);
        repeat (3) @(negedge clk);
        check_state(tag);
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        repeat (2) @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        n_reset = 1'b0; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; rd = 1'b0;
        m_ovr = 1'b0; stat_exp = '0;
        do_reset("t0");

        // 1: two bytes, show-ahead head, pops
        frame_begin();
        send_byte(8'hA5, 1'b0, "t1 b0", mb);
        send_byte(8'h3C, 1'b0, "t1 b1", mb);
        frame_end();
        chk("t1 count2", count, 2);
        chk("t1 headA5", data, 8'hA5);
        pop_one("t1 pop0");
        chk("t1 head3C", data, 8'h3C);
        pop_one("t1 pop1");
        chk("t1 empty", d_avail, 0);
        pop_one("t1 pop empty");

        // 2: partial byte discarded by SS high
        do_reset("t2");
        frame_begin();
        send_bits(8'hFF, 5, 1'b0, mb);
        frame_end();
        check_state("t2 partial");
        frame_begin();
        send_byte(8'h81, 1'b0, "t2 b", mb);
        frame_end();
        chk("t2 count1", count, 1);
        chk("t2 head81", data, 8'h81);

        // 3: overflow drops the 17th byte
        do_reset("t3");
        frame_begin();
        for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b0, "t3 fill", mb);
        frame_end();
        chk("t3 count16", count, 16);
        chk("t3 head00", data, 8'h00);
        chk("t3 ovr", ovr, OVR_EN);

        // 4: full FIFO, completion coincides with a pop
        do_reset("t4");
        frame_begin();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0, "t4 fill", mb);
        send_byte(8'h20, 1'b1, "t4 pushpop", mb);
        frame_end();
        chk("t4 count16", count, 16);
        chk("t4 no ovr", ovr, 0);
        for (int i = 0; i < 16; i++) pop_one("t4 drain");

        // 5: status readback with 3 bytes held
        do_reset("t5");
        frame_begin();
        for (int i = 0; i < 3; i++) send_byte(8'(8'h70 + i), 1'b0, "t5 fill", mb);
        frame_end();
        frame_begin();
        send_byte(8'hE7, 1'b0, "t5 read", mb);
        chk("t5 status 0D", mb, 8'h0D);
        frame_end();

        // 6: reset mid-byte with 6 bytes stored
        do_reset("t6 pre");
        frame_begin();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h90 + i), 1'b0, "t6 fill", mb);
        send_bits(8'hC3, 4, 1'b0, mb);
        do_reset("t6 mid");
        frame_begin();
        send_byte(8'h55, 1'b0, "t6 b", mb);
        frame_end();
        chk("t6 head55", data, 8'h55);
        chk("t6 count1", count, 1);

        // Random traffic against the queue model
        do_reset("rnd");
        for (int r = 0; r < 20; r++) begin
            int nb, np;
            frame_begin();
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) send_byte(8'($urandom), 1'b0, "rnd byte", mb);
            if ($urandom_range(0, 4) == 0) send_bits(8'($urandom), $urandom_range(1, 7), 1'b0, mb);
            frame_end();
            check_state("rnd frame");
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) pop_one("rnd pop");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
